// File: rtl/game_timer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : timer_pkg
// Description : Shared definitions for the game_timer block: state encoding
//               of the play-time FSM and the BCD digit widths and limits used
//               by the MM:SS cascade.
// Revision    : 1.0 - initial release
// ============================================================================
package timer_pkg;

    // FSM state encoding (explicit 2-bit width)
    typedef logic [1:0] state_t;

    localparam state_t c_ST_IDLE  = 2'd0;
    localparam state_t c_ST_RUN   = 2'd1;
    localparam state_t c_ST_PAUSE = 2'd2;
    localparam state_t c_ST_DONE  = 2'd3;

    // BCD digit widths for the MM:SS display
    localparam int c_SEC_ONES_W = 4;
    localparam int c_SEC_TENS_W = 3;
    localparam int c_MIN_ONES_W = 4;
    localparam int c_MIN_TENS_W = 4;

    // Largest value each digit holds before it wraps and carries
    localparam logic [c_SEC_ONES_W-1:0] c_BCD_MAX_UNITS    = 4'd9;
    localparam logic [c_SEC_TENS_W-1:0] c_BCD_MAX_SEC_TENS = 3'd5;

endpackage : timer_pkg
`default_nettype wire

// File: rtl/toggle_edge_detect.sv
`default_nettype none
// ============================================================================
// Module      : toggle_edge_detect
// Description : Brings the slow divider toggle into the clk domain through a
//               SYNC_STAGES-deep synchroniser and emits a one-cycle pulse for
//               every level change (rising and falling alike).
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk        in   1  system clock
//   reset      in   1  synchronous, active-high reset
//   sec_toggle in   1  divider output; each level change is one second
//   sec_tick   out  1  one-cycle pulse per detected level change
// ============================================================================
module toggle_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic sec_toggle,
    output logic sec_tick
);

    // r_sync[0] is the first capture flop; r_sync[SYNC_STAGES-1] is the
    // synchronised value that downstream logic may safely use.
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_hist;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync <= '0;
            r_hist <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], sec_toggle};
            r_hist <= r_sync[SYNC_STAGES-1];
        end
    end

    // Both inputs of the XOR are flops, so the pulse is clean and lasts
    // exactly one cycle: the history flop catches up at the next edge.
    assign sec_tick = r_sync[SYNC_STAGES-1] ^ r_hist;

endmodule : toggle_edge_detect
`default_nettype wire

// File: rtl/game_timer.sv
`default_nettype none
// ============================================================================
// Module      : game_timer
// Description : Elapsed play-time counter for the sudoku game. Turns each
//               level change of the divider toggle into a one-second tick and
//               accumulates MM:SS in BCD under start/pause/clear control,
//               saturating at MAX_MIN:59.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk        in   1  system clock (50 MHz)
//   reset      in   1  synchronous, active-high reset
//   sec_toggle in   1  divider output; each level change is one second
//   start      in   1  level command: begin or resume counting
//   pause      in   1  level command: suspend counting
//   clear      in   1  level command: zero time and return to idle
//   sec_ones   out  4  BCD seconds units (0..9)
//   sec_tens   out  3  BCD seconds tens (0..5)
//   min_ones   out  4  BCD minutes units (0..9)
//   min_tens   out  4  BCD minutes tens (0..9)
//   running    out  1  high while counting
//   done       out  1  high while saturated at MAX_MIN:59
//   sec_tick   out  1  one-cycle pulse per detected second, any state
// ============================================================================
module game_timer
    import timer_pkg::*;
#(
    parameter int MAX_MIN     = 99,
    parameter int SYNC_STAGES = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    sec_toggle,
    input  logic                    start,
    input  logic                    pause,
    input  logic                    clear,
    output logic [c_SEC_ONES_W-1:0] sec_ones,
    output logic [c_SEC_TENS_W-1:0] sec_tens,
    output logic [c_MIN_ONES_W-1:0] min_ones,
    output logic [c_MIN_TENS_W-1:0] min_tens,
    output logic                    running,
    output logic                    done,
    output logic                    sec_tick
);

    // Saturation point split into BCD minute digits; the last counted
    // second before the stop point is MAX_MIN:58.
    localparam logic [c_MIN_ONES_W-1:0] c_MAX_MIN_ONES  = c_MIN_ONES_W'(MAX_MIN % 10);
    localparam logic [c_MIN_TENS_W-1:0] c_MAX_MIN_TENS  = c_MIN_TENS_W'(MAX_MIN / 10);
    localparam logic [c_SEC_ONES_W-1:0] c_LAST_SEC_ONES = 4'd8;

    // ------------------------------------------------------------------------
    // Second tick extraction
    // ------------------------------------------------------------------------
    logic w_sec_tick;

    toggle_edge_detect #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_edge_detect (
        .clk        (clk),
        .reset      (reset),
        .sec_toggle (sec_toggle),
        .sec_tick   (w_sec_tick)
    );

    // ------------------------------------------------------------------------
    // State and time registers
    // ------------------------------------------------------------------------
    state_t                  r_state;
    state_t                  w_state_nx;
    logic                    r_running;
    logic                    r_done;

    logic [c_SEC_ONES_W-1:0] r_sec_ones;
    logic [c_SEC_TENS_W-1:0] r_sec_tens;
    logic [c_MIN_ONES_W-1:0] r_min_ones;
    logic [c_MIN_TENS_W-1:0] r_min_tens;

    logic [c_SEC_ONES_W-1:0] w_sec_ones_inc;
    logic [c_SEC_TENS_W-1:0] w_sec_tens_inc;
    logic [c_MIN_ONES_W-1:0] w_min_ones_inc;
    logic [c_MIN_TENS_W-1:0] w_min_tens_inc;

    logic                    w_count;
    logic                    w_at_last;
    logic                    w_carry_sec_ones;
    logic                    w_carry_sec_tens;
    logic                    w_carry_min_ones;

    // Only a tick seen while the registered state is RUN advances time, so a
    // tick coinciding with start from IDLE/PAUSE is deliberately dropped.
    assign w_count = (r_state == c_ST_RUN) && w_sec_tick;

    // Time currently reads MAX_MIN:58: the next counted tick saturates.
    assign w_at_last = (r_min_tens == c_MAX_MIN_TENS)     &&
                       (r_min_ones == c_MAX_MIN_ONES)     &&
                       (r_sec_tens == c_BCD_MAX_SEC_TENS) &&
                       (r_sec_ones == c_LAST_SEC_ONES);

    // ------------------------------------------------------------------------
    // BCD increment cascade (time + 1 s)
    // ------------------------------------------------------------------------
    assign w_carry_sec_ones = (r_sec_ones == c_BCD_MAX_UNITS);
    assign w_carry_sec_tens = w_carry_sec_ones && (r_sec_tens == c_BCD_MAX_SEC_TENS);
    assign w_carry_min_ones = w_carry_sec_tens && (r_min_ones == c_BCD_MAX_UNITS);

    always_comb begin
        w_sec_ones_inc = r_sec_ones;
        w_sec_tens_inc = r_sec_tens;
        w_min_ones_inc = r_min_ones;
        w_min_tens_inc = r_min_tens;

        if (w_carry_sec_ones) begin
            w_sec_ones_inc = '0;
        end else begin
            w_sec_ones_inc = r_sec_ones + 4'd1;
        end

        if (w_carry_sec_tens) begin
            w_sec_tens_inc = '0;
        end else if (w_carry_sec_ones) begin
            w_sec_tens_inc = r_sec_tens + 3'd1;
        end

        if (w_carry_min_ones) begin
            w_min_ones_inc = '0;
        end else if (w_carry_sec_tens) begin
            w_min_ones_inc = r_min_ones + 4'd1;
        end

        // Saturation stops the count at MAX_MIN:59 (MAX_MIN <= 99), so the
        // minute tens digit never needs to wrap.
        if (w_carry_min_ones) begin
            w_min_tens_inc = r_min_tens + 4'd1;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic: clear > pause > start
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nx = r_state;
        if (clear) begin
            w_state_nx = c_ST_IDLE;
        end else begin
            case (r_state)
                c_ST_IDLE,
                c_ST_PAUSE: begin
                    if (start && !pause) begin
                        w_state_nx = c_ST_RUN;
                    end
                end
                c_ST_RUN: begin
                    // The saturating tick wins over a simultaneous pause;
                    // otherwise a tick with pause is counted, then we park.
                    if (w_sec_tick && w_at_last) begin
                        w_state_nx = c_ST_DONE;
                    end else if (pause) begin
                        w_state_nx = c_ST_PAUSE;
                    end
                end
                c_ST_DONE: begin
                    w_state_nx = c_ST_DONE;
                end
                default: begin
                    w_state_nx = c_ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Registers; status flags decode the next state so they line up with it
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= c_ST_IDLE;
            r_running  <= 1'b0;
            r_done     <= 1'b0;
            r_sec_ones <= '0;
            r_sec_tens <= '0;
            r_min_ones <= '0;
            r_min_tens <= '0;
        end else begin
            r_state   <= w_state_nx;
            r_running <= (w_state_nx == c_ST_RUN);
            r_done    <= (w_state_nx == c_ST_DONE);

            if (clear) begin
                r_sec_ones <= '0;
                r_sec_tens <= '0;
                r_min_ones <= '0;
                r_min_tens <= '0;
            end else if (w_count) begin
                r_sec_ones <= w_sec_ones_inc;
                r_sec_tens <= w_sec_tens_inc;
                r_min_ones <= w_min_ones_inc;
                r_min_tens <= w_min_tens_inc;
            end
        end
    end

    assign sec_ones = r_sec_ones;
    assign sec_tens = r_sec_tens;
    assign min_ones = r_min_ones;
    assign min_tens = r_min_tens;
    assign running  = r_running;
    assign done     = r_done;
    assign sec_tick = w_sec_tick;

endmodule : game_timer
`default_nettype wire
